cla_multiword_adder: RTL and testbench
======================================

Name: cla_multiword_adder

Overview:
- Sequential multi-precision adder. Consumes operands as a stream of 16-bit words, least-significant word first.
- Adds each word pair with a single instance of the team's 16-bit CLA, whose Sum/Cout feed this block's registers. The carry is held in a register between words, so WORDS×16-bit additions run on one 16-bit datapath.
- Results leave through a one-deep output register with valid/ready backpressure.

Parameters:
- WORDS, 4, number of 16-bit words per operand (total width 16×WORDS); legal range 2..256.
- CW, $clog2(WORDS), word-index counter width (derived; do not override).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Flush  input  1  synchronous abort of the current operand: clears the index, carry and output valid.
- InValid  input  1  A/B/Cin present a word pair.
- InReady  output  1  block can accept a word pair this cycle.
- A  input  16  operand A word.
- B  input  16  operand B word.
- Cin  input  1  initial carry-in; sampled only on word index 0.
- OutValid  output  1  Sum/OutLast/Cout/Ovf hold a valid result word.
- OutReady  input  1  downstream accepts the result word.
- Sum  output  16  result word.
- OutLast  output  1  result word is the most-significant word of the operand.
- Cout  output  1  final carry-out; meaningful only when OutLast=1, otherwise 0.
- Ovf  output  1  signed (two's-complement) overflow; meaningful only when OutLast=1, otherwise 0.
- WordIdx  output  CW  index of the next word to be accepted (debug/status).

Behaviour:
- Reset: Rst=1 clears OutValid, Sum, OutLast, Cout, Ovf, WordIdx, the carry register and the FSM (state FIRST) immediately, without waiting for a clock edge.
- Handshake:
  - InReady = !OutValid | OutReady. This is a combinational pass-through of OutReady, so full throughput is one word per cycle.
  - accept = InValid & InReady & !Flush.
  - A word transfers out when OutValid & OutReady.
- Carry into the CLA: Cin when state=FIRST, otherwise the carry register.
- On accept, at the clock edge:
  - Sum ← CLA Sum; OutValid ← 1; carry register ← CLA Cout.
  - OutLast ← (WordIdx==WORDS-1).
  - Cout ← CLA Cout if last, else 0.
  - Ovf ← (A[15]==B[15]) & (Sum[15]!=A[15]) if last, else 0.
- Without an accept: if the output transfers, OutValid ← 0, and Sum and flags hold their values. If it does not transfer, all outputs hold. Sum must never change while OutValid=1 and OutReady=0.
- Latency: 1 cycle from accept to OutValid.
- FSM: FIRST (WordIdx=0) and RUN (WordIdx 1..WORDS-1).
  - FIRST → RUN on accept.
  - RUN increments WordIdx on each accept.
  - Accepting word WORDS-1 wraps WordIdx to 0 and returns the FSM to FIRST, so the next accept starts a new operand with a fresh Cin.
  - WORDS=2 uses both states.
- Simultaneous output transfer and new accept in one cycle: the new word is loaded and OutValid stays 1, with no bubble.
- Flush=1 at an edge:
  - WordIdx ← 0, FSM → FIRST, carry ← 0, OutValid ← 0, OutLast/Cout/Ovf ← 0.
  - Any InValid in that cycle is dropped. Flush has priority over accept.
- Rst or Flush mid-operand discards all partial words. There is no partial-result signalling.
- Arithmetic is modulo 2^(16×WORDS). The carry register is exactly 1 bit.

Test Plan (WORDS=4, OutReady=1 unless stated, words listed LSW first):
1. A=FFFF,FFFF,FFFF,FFFF; B=0001,0000,0000,0000; Cin=0, back-to-back words → Sum=0000,0000,0000,0000 on 4 consecutive cycles; OutLast=1 and Cout=1, Ovf=0 on word 3.
2. A=1234,0000,0000,0000; B=5678,0000,0000,0000; Cin=1 → Sum=68AD,0000,0000,0000; Cout=0, Ovf=0. Then immediately A=ABCD,…; B=4321,… (upper words 0), Cin=0 → first Sum=EEEE, confirming that Cin is resampled on the new operand.
3. Backpressure: during test 2, hold OutReady=0 for 3 cycles after the first result → InReady=0, Sum holds 68AD, no word lost or duplicated, WordIdx stays 1.
4. Signed overflow: A=FFFF,FFFF,FFFF,7FFF; B=0001,0000,0000,0000; Cin=0 → Sum=0000,0000,0000,8000; OutLast word has Ovf=1, Cout=0.
5. Reset mid-operand: assert Rst asynchronously after 2 words of test 1 → OutValid=0 and WordIdx=0 without a clock edge. Next operand A=0000×4, B=FFFF×4, Cin=1 → Sum=0000×4, Cout=1.
6. Flush with InValid=1 in the same cycle, after word 1 → the word is dropped, OutValid=0 next cycle, WordIdx=0. The following operand computes correctly with a fresh Cin.

Source files
------------

// File: rtl/cla_multiword_adder.sv
// Multi-precision adder: streams 16-bit word pairs LSW first through one 16-bit CLA,
// chaining the carry in a 1-bit register and presenting each result in a one-deep output stage.

module Cla16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);
   logic [15:0] g, p, c;
   logic [3:0]  gg, gp;
   logic [4:0]  cg;

   // Four 4-bit groups; group carries are fully looked ahead, bit carries ripple inside a group.
   always_comb begin
      g = a & b;
      p = a ^ b;
      for (int k = 0; k < 4; k++) begin
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         gp[k] = &p[4*k +: 4];
      end
      cg[0] = cin;
      cg[1] = gg[0] | (gp[0] & cg[0]);
      cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cg[0]);
      cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
            | (gp[2] & gp[1] & gp[0] & cg[0]);
      cg[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
            | (gp[3] & gp[2] & gp[1] & gg[0]) | ((&gp) & cg[0]);
      c = '0;
      for (int k = 0; k < 4; k++) begin
         c[4*k] = cg[k];
         for (int j = 1; j < 4; j++) begin
            c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
         end
      end
      sum  = p ^ c;
      cout = cg[4];
   end
endmodule

module cla_multiword_adder #(
   parameter int WORDS = 4,
   parameter int CW    = $clog2(WORDS)
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          Flush,
   input  logic          InValid,
   output logic          InReady,
   input  logic [15:0]   A,
   input  logic [15:0]   B,
   input  logic          Cin,
   output logic          OutValid,
   input  logic          OutReady,
   output logic [15:0]   Sum,
   output logic          OutLast,
   output logic          Cout,
   output logic          Ovf,
   output logic [CW-1:0] WordIdx
);
   typedef enum logic {FIRST, RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] idx_q, idx_d;
   logic          carry_q, carry_d;
   logic          valid_q, valid_d;
   logic [15:0]   sum_q, sum_d;
   logic          last_q, last_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;

   logic          accept, lastWord, claCin, claCout;
   logic [15:0]   claSum;

   assign InReady  = !valid_q | OutReady;
   assign accept   = InValid & InReady & !Flush;
   assign lastWord = (idx_q == CW'(WORDS - 1));
   assign claCin   = (state_q == FIRST) ? Cin : carry_q;

   Cla16 uCla (
      .a    (A),
      .b    (B),
      .cin  (claCin),
      .sum  (claSum),
      .cout (claCout)
   );

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= FIRST;
         idx_q   <= '0;
         carry_q <= 1'b0;
         valid_q <= 1'b0;
         sum_q   <= '0;
         last_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         valid_q <= valid_d;
         sum_q   <= sum_d;
         last_q  <= last_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // Word sequencing: the last word of an operand wraps back to FIRST so Cin is resampled.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (Flush) begin
         state_d = FIRST;
         idx_d   = '0;
      end else if (accept) begin
         if (lastWord) begin
            state_d = FIRST;
            idx_d   = '0;
         end else begin
            state_d = RUN;
            idx_d   = idx_q + CW'(1);
         end
      end
   end

   // Output stage: Sum only changes on a load, so it is stable while stalled.
   always_comb begin
      carry_d = carry_q;
      valid_d = valid_q;
      sum_d   = sum_q;
      last_d  = last_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      if (Flush) begin
         carry_d = 1'b0;
         valid_d = 1'b0;
         last_d  = 1'b0;
         cout_d  = 1'b0;
         ovf_d   = 1'b0;
      end else if (accept) begin
         carry_d = claCout;
         valid_d = 1'b1;
         sum_d   = claSum;
         last_d  = lastWord;
         cout_d  = lastWord & claCout;
         ovf_d   = lastWord & (A[15] == B[15]) & (claSum[15] != A[15]);
      end else if (valid_q && OutReady) begin
         valid_d = 1'b0;
      end
   end

   assign OutValid = valid_q;
   assign Sum      = sum_q;
   assign OutLast  = last_q;
   assign Cout     = cout_q;
   assign Ovf      = ovf_q;
   assign WordIdx  = idx_q;
endmodule

// File: tb/tb_cla_multiword_adder.sv
// Directed bench for cla_multiword_adder (WORDS=4): full-width arithmetic model
// predicts every result word, plus literal checks from hand-computed vectors.

module tb_cla_multiword_adder;
   localparam int W   = 4;
   localparam int CWB = $clog2(W);

   logic           Clk = 1'b0;
   logic           Rst, Flush, InValid, InReady, Cin, OutValid, OutReady;
   logic           OutLast, Cout, Ovf;
   logic [15:0]    A, B, Sum;
   logic [CWB-1:0] WordIdx;

   typedef struct packed {
      logic [15:0] sum;
      logic        last;
      logic        cout;
      logic        ovf;
   } res_t;

   res_t        expQ[$];
   res_t        obsLog[$];
   int          total = 0;
   int          bad   = 0;
   logic [63:0] opA, opB;
   logic        opCin;

   cla_multiword_adder #(.WORDS(W)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .Flush    (Flush),
      .InValid  (InValid),
      .InReady  (InReady),
      .A        (A),
      .B        (B),
      .Cin      (Cin),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .Sum      (Sum),
      .OutLast  (OutLast),
      .Cout     (Cout),
      .Ovf      (Ovf),
      .WordIdx  (WordIdx)
   );

   always #5 Clk = ~Clk;

   // Model: add the whole operands at full width, then slice out word i.
   function automatic res_t modelWord(input logic [63:0] a, input logic [63:0] b,
                                      input logic cin, input int i);
      logic [64:0] full;
      res_t        r;
      full   = {1'b0, a} + {1'b0, b} + {64'd0, cin};
      r.sum  = full[16*i +: 16];
      r.last = (i == W - 1);
      r.cout = r.last ? full[64] : 1'b0;
      r.ovf  = r.last ? ((a[63] == b[63]) && (full[63] != a[63])) : 1'b0;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Present word i of the current operand and wait for it to be taken.
   task automatic applyStimulus(input int i);
      bit got;
      A       = opA[16*i +: 16];
      B       = opB[16*i +: 16];
      Cin     = (i == 0) ? opCin : ~opCin;
      InValid = 1'b1;
      got     = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge Clk);
         if (InReady) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("[TB] FAIL accept_timeout word=%0d actual=InReady_low required=accept", i);
      end else begin
         @(posedge Clk);
         #1;
         expQ.push_back(modelWord(opA, opB, opCin, i));
      end
   endtask

   task automatic sendOperand(input logic [63:0] a, input logic [63:0] b, input logic cin);
      opA   = a;
      opB   = b;
      opCin = cin;
      for (int i = 0; i < W; i++) applyStimulus(i);
   endtask

   task automatic drain();
      InValid = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
   endtask

   // Compare every transferred word against the model; also watch handshake and stall stability.
   always @(negedge Clk) begin : monitor
      logic        prevHold;
      logic [15:0] prevSum;
      res_t        e;
      if (!Rst) begin
         checkOutput("in_ready", {31'd0, InReady}, {31'd0, (!OutValid | OutReady)});
         if (prevHold && OutValid) checkOutput("sum_stall_hold", {16'd0, Sum}, {16'd0, prevSum});
         if (OutValid && OutReady) begin
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL extra_word actual=%h required=none", Sum);
            end else begin
               e = expQ.pop_front();
               checkOutput("sum",  {16'd0, Sum},     {16'd0, e.sum});
               checkOutput("last", {31'd0, OutLast}, {31'd0, e.last});
               checkOutput("cout", {31'd0, Cout},    {31'd0, e.cout});
               checkOutput("ovf",  {31'd0, Ovf},     {31'd0, e.ovf});
            end
            obsLog.push_back('{sum: Sum, last: OutLast, cout: Cout, ovf: Ovf});
         end
         prevHold = OutValid && !OutReady;
         prevSum  = Sum;
      end else begin
         prevHold = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      Rst = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
      A = '0; B = '0; Cin = 1'b0;
      opA = '0; opB = '0; opCin = 1'b0;
      #1;
      checkOutput("rst_valid",   {31'd0, OutValid}, 32'd0);
      checkOutput("rst_sum",     {16'd0, Sum},      32'd0);
      checkOutput("rst_idx",     32'(WordIdx),      32'd0);
      checkOutput("rst_flags",   {29'd0, OutLast, Cout, Ovf}, 32'd0);
      repeat (2) @(posedge Clk);
      #1;
      Rst = 1'b0;

      // Carry ripples across all four words.
      obsLog.delete();
      sendOperand(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
      drain();
      checkOutput("t1_count", 32'(obsLog.size()), 32'd4);
      if (obsLog.size() == 4) begin
         for (int i = 0; i < 4; i++) checkOutput("t1_sum", {16'd0, obsLog[i].sum}, 32'd0);
         checkOutput("t1_w0_last", {31'd0, obsLog[0].last}, 32'd0);
         checkOutput("t1_w3_flags", {29'd0, obsLog[3].last, obsLog[3].cout, obsLog[3].ovf}, 32'b110);
      end

      // Cin=1 operand with a 3-cycle stall after the first result, then a back-to-back operand.
      obsLog.delete();
      opA = 64'h1234; opB = 64'h5678; opCin = 1'b1;
      applyStimulus(0);
      OutReady = 1'b0;
      A = opA[31:16]; B = opB[31:16]; Cin = 1'b0; InValid = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge Clk);
         checkOutput("t3_inready", {31'd0, InReady},  32'd0);
         checkOutput("t3_valid",   {31'd0, OutValid}, 32'd1);
         checkOutput("t3_sum",     {16'd0, Sum},      32'h68AD);
         checkOutput("t3_idx",     32'(WordIdx),      32'd1);
         @(posedge Clk);
         #1;
      end
      OutReady = 1'b1;
      for (int i = 1; i < W; i++) applyStimulus(i);
      sendOperand(64'hABCD, 64'h4321, 1'b0);
      drain();
      checkOutput("t2_count", 32'(obsLog.size()), 32'd8);
      if (obsLog.size() == 8) begin
         checkOutput("t2_w0", {16'd0, obsLog[0].sum}, 32'h68AD);
         checkOutput("t2_w1", {16'd0, obsLog[1].sum}, 32'h0000);
         checkOutput("t2_w3_flags", {29'd0, obsLog[3].last, obsLog[3].cout, obsLog[3].ovf}, 32'b100);
         checkOutput("t2_next_w0", {16'd0, obsLog[4].sum}, 32'hEEEE);
      end

      // Signed overflow on the most-significant word.
      obsLog.delete();
      sendOperand(64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
      drain();
      if (obsLog.size() == 4) begin
         checkOutput("t4_w3_sum", {16'd0, obsLog[3].sum}, 32'h8000);
         checkOutput("t4_w3_flags", {29'd0, obsLog[3].last, obsLog[3].cout, obsLog[3].ovf}, 32'b101);
      end else begin
         checkOutput("t4_count", 32'(obsLog.size()), 32'd4);
      end

      // Asynchronous reset after two words.
      opA = 64'hFFFF_FFFF_FFFF_FFFF; opB = 64'h1; opCin = 1'b0;
      applyStimulus(0);
      applyStimulus(1);
      InValid = 1'b0;
      #1 Rst = 1'b1;
      #1;
      checkOutput("t5_async_valid", {31'd0, OutValid}, 32'd0);
      checkOutput("t5_async_idx",   32'(WordIdx),      32'd0);
      expQ.delete();
      #1 Rst = 1'b0;
      @(posedge Clk);
      #1;
      obsLog.delete();
      sendOperand(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      drain();
      if (obsLog.size() == 4) begin
         for (int i = 0; i < 4; i++) checkOutput("t5_sum", {16'd0, obsLog[i].sum}, 32'd0);
         checkOutput("t5_cout", {31'd0, obsLog[3].cout}, 32'd1);
      end else begin
         checkOutput("t5_count", 32'(obsLog.size()), 32'd4);
      end

      // Flush with a word offered in the same cycle.
      opA = 64'hFFFF_FFFF_FFFF_FFFF; opB = 64'h1; opCin = 1'b0;
      applyStimulus(0);
      applyStimulus(1);
      Flush = 1'b1; InValid = 1'b1; A = opA[47:32]; B = opB[47:32];
      @(posedge Clk);
      #1;
      Flush = 1'b0; InValid = 1'b0;
      @(negedge Clk);
      checkOutput("t6_valid", {31'd0, OutValid}, 32'd0);
      checkOutput("t6_idx",   32'(WordIdx),      32'd0);
      checkOutput("t6_queue", 32'(expQ.size()),  32'd0);
      @(posedge Clk);
      #1;
      obsLog.delete();
      sendOperand(64'h0001_0002_0003_FFFF, 64'h0000_0000_0000_0001, 1'b1);
      drain();
      if (obsLog.size() == 4) begin
         checkOutput("t6_w0", {16'd0, obsLog[0].sum}, 32'h0001);
         checkOutput("t6_w1", {16'd0, obsLog[1].sum}, 32'h0004);
         checkOutput("t6_w3", {16'd0, obsLog[3].sum}, 32'h0001);
      end else begin
         checkOutput("t6_count", 32'(obsLog.size()), 32'd4);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
